// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter_pkg
//  Description : Shared types and constants for the iterative divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_iter_pkg;

    // Divider control states; the done pulse is a register, not a state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    // Widest operand the all-ones divide-by-zero quotient is provided for
    localparam int MAX_WIDTH = 64;

    // Quotient reported for a zero divisor; users take the low WIDTH bits
    localparam logic [MAX_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage
`default_nettype wire

// File: rtl/div_sub.sv
`default_nettype none
// ============================================================================
//  Module      : div_sub
//  Description : W-bit subtractor computing a - b as a + ~b + 1 from
//                full-adder generate/propagate terms, with 4-bit group
//                lookahead between groups. borrow=1 when a < b (unsigned).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_sub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    localparam int NG = (W + 3) / 4;

    logic [W-1:0]  w_bn;
    logic [W-1:0]  w_g;
    logic [W-1:0]  w_p;
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG-1:0] grp_c;
    logic          carry;

    // Per-bit full-adder terms with the subtrahend inverted
    assign w_bn = ~b;
    assign w_g  = a & w_bn;
    assign w_p  = a ^ w_bn;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int LO = 4 * k;
        localparam int HI = (4 * k + 3 < W) ? (4 * k + 3) : (W - 1);
        localparam int GW = HI - LO + 1;

        logic [GW-1:0] gg;
        logic [GW-1:0] pp;
        logic [GW-1:0] ds;
        logic          gen_r;
        logic          prop_r;
        logic          c;

        assign gg = w_g[HI:LO];
        assign pp = w_p[HI:LO];

        // Group generate/propagate for the lookahead chain
        always_comb begin
            gen_r  = 1'b0;
            prop_r = 1'b1;
            for (int j = 0; j < GW; j++) begin
                gen_r  = gg[j] | (pp[j] & gen_r);
                prop_r = prop_r & pp[j];
            end
        end

        // Full-adder sum bits rippling from the group carry-in
        always_comb begin
            ds = '0;
            c  = grp_c[k];
            for (int j = 0; j < GW; j++) begin
                ds[j] = pp[j] ^ c;
                c     = gg[j] | (pp[j] & c);
            end
        end

        assign grp_g[k]   = gen_r;
        assign grp_p[k]   = prop_r;
        assign diff[HI:LO] = ds;
    end

    // Group carry lookahead; the +1 of two's complement is the chain carry-in
    always_comb begin
        grp_c = '0;
        carry = 1'b1;
        for (int k = 0; k < NG; k++) begin
            grp_c[k] = carry;
            carry    = grp_g[k] | (grp_p[k] & carry);
        end
    end

    assign borrow = ~carry;

endmodule
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter
//  Description : Iterative radix-2 restoring divider (DIV/DIVU) with a
//                start/busy/done handshake, cancel and divide-by-zero flag.
//                One trial subtraction per cycle, sign fix-up in a final cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;          // dividend shifting out, quotient in
    logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder (always < divisor)
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dsr_abs;
    logic             unused_trial_msb;

    // The partial remainder stays below the divisor, so the trial MSB of an
    // accepted subtraction is always zero and only WIDTH bits are stored
    assign w_shift          = {rem_q, q_q[WIDTH-1]};
    assign unused_trial_msb = w_trial[WIDTH];

    div_sub #(
        .W      (WIDTH + 1)
    ) u_sub (
        .a      (w_shift),
        .b      ({1'b0, dsr_q}),
        .diff   (w_trial),
        .borrow (w_borrow)
    );

    assign w_dvd_abs = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dsr_abs = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Next-state, datapath and result logic
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    if (divisor == '0) begin
                        // Zero divisor finishes immediately with the raw dividend
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                        quot_d = DIV_ZERO_Q[WIDTH-1:0];
                        remo_d = dividend;
                    end else begin
                        q_d     = w_dvd_abs;
                        dsr_d   = w_dsr_abs;
                        q_neg_d = signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_d = signed_div & dividend[WIDTH-1];
                        rem_d   = '0;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    if (!w_borrow) begin
                        rem_d = w_trial[WIDTH-1:0];
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = w_shift[WIDTH-1:0];
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!cancel) begin
                    quot_d = q_neg_q ? -q_q : q_q;
                    remo_d = r_neg_q ? -rem_q : rem_q;
                    dbz_d  = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_iter
//  Description : Directed self-checking bench for div_iter (WIDTH=32).
//                Latency is counted in rising edges after the edge that
//                samples start: 33 further edges (34 including the sampling
//                edge) for a divide, none for a zero divisor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int dn;

    div_iter #(
        .WIDTH       (32),
        .CNT_W       (6)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .signed_div  (signed_div),
        .dividend    (dividend),
        .divisor     (divisor),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present operands with start for exactly one sampling edge
    task automatic start_op(input logic sd, input logic [31:0] a, input logic [31:0] b);
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Wait (bounded) for done; n0 edges have already passed since sampling
    task automatic wait_done(input int n0, input int exp_lat, input string tag);
        int n;
        n = n0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, n, exp_lat);
    endtask

    task automatic chk_res(input string tag, input logic [31:0] q, input logic [31:0] r,
                           input logic z);
        chk({tag, " quotient"}, quotient, q);
        chk({tag, " remainder"}, remainder, r);
        chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, z});
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        dividend   = '0;
        divisor    = '0;
        cancel     = 1'b0;
        repeat (2) tick();
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk_res("reset", 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // DIVU 100/7, including busy and single-cycle done
        start_op(1'b0, 32'd100, 32'd7);
        chk("divu busy", {31'd0, busy}, 32'd1);
        wait_done(0, 33, "divu 100/7");
        chk_res("divu 100/7", 32'd14, 32'd2, 1'b0);
        chk("divu busy at done", {31'd0, busy}, 32'd0);
        tick();
        chk("done pulse width", {31'd0, done}, 32'd0);

        // DIV -7/2, then 7/-2 started in the done cycle of the first
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, 33, "div -7/2");
        chk_res("div -7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(0, 33, "div 7/-2");
        chk_res("div 7/-2", 32'hFFFF_FFFD, 32'd1, 1'b0);

        // Signed overflow wraps; unsigned view of the same operands
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, 33, "div min/-1");
        chk_res("div min/-1", 32'h8000_0000, 32'd0, 1'b0);
        start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, 33, "divu 8000/ffff");
        chk_res("divu 8000/ffff", 32'd0, 32'h8000_0000, 1'b0);

        // DIV -100/-7 -> 14 remainder -2
        start_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        wait_done(0, 33, "div -100/-7");
        chk_res("div -100/-7", 32'd14, 32'hFFFF_FFFE, 1'b0);

        // Zero divisor: done in the very next cycle, raw dividend as remainder
        start_op(1'b0, 32'd5, 32'd0);
        wait_done(0, 0, "divu 5/0");
        chk("div0 busy", {31'd0, busy}, 32'd0);
        chk_res("divu 5/0", 32'hFFFF_FFFF, 32'd5, 1'b1);
        tick();
        start_op(1'b1, 32'hFFFF_FFF8, 32'd0);
        wait_done(0, 0, "div -8/0");
        chk_res("div -8/0", 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1);
        tick();

        // Cancel at cycle 10: no done, previous result held
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel busy", {31'd0, busy}, 32'd0);
        dn = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) dn++;
        end
        chk("cancel no done", dn, 32'd0);
        chk_res("cancel held", 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1);

        start_op(1'b0, 32'd9, 32'd3);
        wait_done(0, 33, "divu 9/3");
        chk_res("divu 9/3", 32'd3, 32'd0, 1'b0);
        tick();

        // cancel in IDLE beats a simultaneous start
        signed_div = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        start      = 1'b1;
        cancel     = 1'b1;
        tick();
        start      = 1'b0;
        cancel     = 1'b0;
        chk("idle cancel busy", {31'd0, busy}, 32'd0);
        dn = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) dn++;
        end
        chk("idle cancel no done", dn, 32'd0);
        chk_res("idle cancel held", 32'd3, 32'd0, 1'b0);

        // A second start at cycle 5 is ignored
        start_op(1'b0, 32'd100, 32'd7);
        repeat (4) tick();
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(5, 33, "busy start");
        chk_res("busy start", 32'd14, 32'd2, 1'b0);
        tick();

        // Asynchronous reset at cycle 20 of an operation
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (20) tick();
        resetn = 1'b0;
        #1;
        chk("async rst busy", {31'd0, busy}, 32'd0);
        chk("async rst done", {31'd0, done}, 32'd0);
        chk_res("async rst", 32'd0, 32'd0, 1'b0);
        repeat (2) tick();
        @(negedge clk);
        resetn = 1'b1;
        dn = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) dn++;
        end
        chk("post reset no done", dn, 32'd0);

        // Normal operation after reset
        start_op(1'b0, 32'd1000, 32'd3);
        wait_done(0, 33, "divu 1000/3");
        chk_res("divu 1000/3", 32'd333, 32'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
